halt_dump_ctrl: RTL and testbench

Sits directly downstream of the pipelined core top and consumes its ECALL/EBREAK pulses and writeback retire strobe. It counts cycles and retired instructions and detects the halt condition: ECALL, EBREAK or cycle timeout. On halt it freezes the core, drains the pipeline for a fixed number of cycles, then streams all 32 architectural registers through a valid/ready port. This replaces the bench-side run loop and register dump with synthesizable logic usable on FPGA.

---
 rtl/halt_dump_ctrl_pkg.sv | 23 ++
 rtl/halt_dump_ctrl_sat_counter.sv | 32 +++
 rtl/halt_dump_ctrl.sv | 166 ++++++++++++++++
 tb/tb_halt_dump_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_dump_ctrl_pkg.sv
// Shared types and constants for the halt/drain/register-dump controller.
package halt_dump_ctrl_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CAUSE_W   = 2;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ECALL   = 2'd1,
        CAUSE_EBREAK  = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/halt_dump_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and a freeze override.
module sat_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !freeze && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/halt_dump_ctrl.sv
// Detects core halt (ebreak/ecall/timeout), freezes and drains the core,
// then streams the 32 architectural registers over a valid/ready port.
module halt_dump_ctrl
    import halt_dump_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned TIMEOUT      = 100,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ecall_pulse,
    input  logic             ebreak_pulse,
    input  logic             retire_valid,
    output logic             core_freeze,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             dump_done
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    state_e               state_q, state_d;
    cause_e               halt_cause_q, halt_cause_d;
    logic                 halted_q, halted_d;
    logic                 core_freeze_q, core_freeze_d;
    logic                 dump_valid_q, dump_valid_d;
    logic                 dump_done_q, dump_done_d;
    logic [REG_IDX_W-1:0] rf_raddr_q, rf_raddr_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

    logic                 timeout_hit_c;
    cause_e               cause_c;
    logic [CNT_W-1:0]     cycle_cnt_w;
    logic [CNT_W-1:0]     retire_cnt_w;

    // Timeout compares the pre-increment count so the halt lands on cycle_cnt == TIMEOUT.
    assign timeout_hit_c = (TIMEOUT != 0) && (cycle_cnt_w == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cause_c = CAUSE_NONE;
        if (ebreak_pulse) begin
            cause_c = CAUSE_EBREAK;
        end else if (ecall_pulse) begin
            cause_c = CAUSE_ECALL;
        end else if (timeout_hit_c) begin
            cause_c = CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        state_d       = state_q;
        halt_cause_d  = halt_cause_q;
        halted_d      = halted_q;
        core_freeze_d = core_freeze_q;
        dump_valid_d  = dump_valid_q;
        dump_done_d   = dump_done_q;
        rf_raddr_d    = rf_raddr_q;
        drain_cnt_d   = drain_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (cause_c != CAUSE_NONE) begin
                    halted_d      = 1'b1;
                    halt_cause_d  = cause_c;
                    core_freeze_d = 1'b1;
                    drain_cnt_d   = DRAIN_W'(DRAIN_CYCLES);
                    rf_raddr_d    = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d      = ST_DUMP;
                        dump_valid_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q <= DRAIN_W'(1)) begin
                    state_d      = ST_DUMP;
                    dump_valid_d = 1'b1;
                    rf_raddr_d   = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_DUMP: begin
                if (dump_valid_q && dump_ready) begin
                    if (rf_raddr_q == LAST_IDX) begin
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        rf_raddr_d = rf_raddr_q + REG_IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            halt_cause_q  <= CAUSE_NONE;
            halted_q      <= 1'b0;
            core_freeze_q <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_done_q   <= 1'b0;
            rf_raddr_q    <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            halt_cause_q  <= halt_cause_d;
            halted_q      <= halted_d;
            core_freeze_q <= core_freeze_d;
            dump_valid_q  <= dump_valid_d;
            dump_done_q   <= dump_done_d;
            rf_raddr_q    <= rf_raddr_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    // Cycles count only while running; retires keep counting through the drain.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (1'b1),
        .freeze (state_q != ST_RUN),
        .cnt    (cycle_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (retire_valid),
        .freeze ((state_q == ST_DUMP) || (state_q == ST_DONE)),
        .cnt    (retire_cnt_w)
    );

    assign cycle_cnt   = cycle_cnt_w;
    assign retire_cnt  = retire_cnt_w;
    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;
    assign core_freeze = core_freeze_q;
    assign rf_raddr    = rf_raddr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_done   = dump_done_q;
    assign dump_idx    = rf_raddr_q;
    // x0 is architecturally zero regardless of what the regfile port returns.
    assign dump_data   = (rf_raddr_q == '0) ? 32'd0 : rf_rdata;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Directed bench for halt_dump_ctrl: default instance plus a TIMEOUT=0, DRAIN_CYCLES=0 instance.
module tb_halt_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst, ecall_pulse, ebreak_pulse, retire_valid, dump_ready;
    logic [4:0]  rf_raddr, dump_idx;
    logic [31:0] rf_rdata, dump_data;
    logic        core_freeze, halted, dump_valid, dump_done;
    logic [1:0]  halt_cause;
    logic [63:0] cycle_cnt, retire_cnt;

    logic        b_rst, b_ecall, b_ebreak, b_retire, b_ready;
    logic [4:0]  b_raddr, b_idx;
    logic [31:0] b_rdata, b_data;
    logic        b_freeze, b_halted, b_valid, b_done;
    logic [1:0]  b_cause;
    logic [63:0] b_cycle, b_retire_cnt;
    logic [63:0] b_edges = 64'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Regfile model: every entry, including x0, holds 0xA5A50000 + index.
    assign rf_rdata = 32'hA5A5_0000 + {27'd0, rf_raddr};
    assign b_rdata  = 32'hA5A5_0000 + {27'd0, b_raddr};

    always @(posedge clk) if (b_rst) b_edges <= b_edges + 64'd1;

    halt_dump_ctrl #(.CNT_W(64), .TIMEOUT(100), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ecall_pulse(ecall_pulse), .ebreak_pulse(ebreak_pulse),
        .retire_valid(retire_valid), .core_freeze(core_freeze), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .halted(halted), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    halt_dump_ctrl #(.CNT_W(64), .TIMEOUT(0), .DRAIN_CYCLES(0)) dut_b (
        .clk(clk), .rst(b_rst), .ecall_pulse(b_ecall), .ebreak_pulse(b_ebreak),
        .retire_valid(b_retire), .core_freeze(b_freeze), .rf_raddr(b_raddr),
        .rf_rdata(b_rdata), .halted(b_halted), .halt_cause(b_cause),
        .cycle_cnt(b_cycle), .retire_cnt(b_retire_cnt), .dump_valid(b_valid),
        .dump_ready(b_ready), .dump_idx(b_idx), .dump_data(b_data),
        .dump_done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        ecall_pulse = 1'b0; ebreak_pulse = 1'b0; retire_valid = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        ecall_pulse = 1'b1; ebreak_pulse = 1'b1; retire_valid = 1'b1;
        repeat (3) tick();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %0d want 0", halted); end
        vectors++; if (cycle_cnt !== 64'd0) begin miscompares++; $display("FAIL rst_cycle: got %0d want 0", cycle_cnt); end
        vectors++; if (retire_cnt !== 64'd0) begin miscompares++; $display("FAIL rst_retire: got %0d want 0", retire_cnt); end
        vectors++; if ({core_freeze, dump_valid, dump_done, halt_cause, rf_raddr} !== 10'd0) begin
            miscompares++; $display("FAIL rst_outputs: got %b want 0", {core_freeze, dump_valid, dump_done, halt_cause, rf_raddr});
        end
        ecall_pulse = 1'b0; ebreak_pulse = 1'b0; retire_valid = 1'b0;
        rst = 1'b1;
        repeat (5) tick();
        vectors++; if (cycle_cnt !== 64'd5) begin miscompares++; $display("FAIL rst_release_cycle: got %0d want 5", cycle_cnt); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_prepulse_ignored: got %0d want 0", halted); end
    endtask

    task automatic test_ebreak_dump();
        logic [31:0] exp;
        apply_reset();
        dump_ready = 1'b1;
        repeat (10) tick();
        vectors++; if (cycle_cnt !== 64'd10) begin miscompares++; $display("FAIL eb_pre_cycle: got %0d want 10", cycle_cnt); end
        ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL eb_halted: got %0d want 1", halted); end
        vectors++; if (halt_cause !== 2'd2) begin miscompares++; $display("FAIL eb_cause: got %0d want 2", halt_cause); end
        vectors++; if (cycle_cnt !== 64'd11) begin miscompares++; $display("FAIL eb_cycle: got %0d want 11", cycle_cnt); end
        vectors++; if (core_freeze !== 1'b1) begin miscompares++; $display("FAIL eb_freeze: got %0d want 1", core_freeze); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL eb_drain_valid%0d: got %0d want 0", k, dump_valid); end
            tick();
        end
        vectors++; if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL eb_drain_valid3: got %0d want 0", dump_valid); end
        tick();
        for (int i = 0; i < 32; i++) begin
            exp = (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
            vectors++; if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL eb_beat_valid%0d: got %0d want 1", i, dump_valid); end
            vectors++; if (dump_idx !== 5'(i)) begin miscompares++; $display("FAIL eb_beat_idx%0d: got %0d want %0d", i, dump_idx, i); end
            vectors++; if (dump_data !== exp) begin miscompares++; $display("FAIL eb_beat_data%0d: got %h want %h", i, dump_data, exp); end
            tick();
        end
        vectors++; if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL eb_end_valid: got %0d want 0", dump_valid); end
        vectors++; if (dump_done !== 1'b1) begin miscompares++; $display("FAIL eb_done: got %0d want 1", dump_done); end
        vectors++; if (cycle_cnt !== 64'd11) begin miscompares++; $display("FAIL eb_cycle_frozen: got %0d want 11", cycle_cnt); end
    endtask

    task automatic test_priority();
        apply_reset();
        repeat (3) tick();
        ecall_pulse = 1'b1; ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        vectors++; if (halt_cause !== 2'd2) begin miscompares++; $display("FAIL prio_cause: got %0d want 2", halt_cause); end
        tick(); tick(); ecall_pulse = 1'b0;
        vectors++; if (halt_cause !== 2'd2) begin miscompares++; $display("FAIL prio_drain_ecall: got %0d want 2", halt_cause); end
        ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        vectors++; if (halt_cause !== 2'd2) begin miscompares++; $display("FAIL prio_drain_ebreak: got %0d want 2", halt_cause); end
        vectors++; if (cycle_cnt !== 64'd4) begin miscompares++; $display("FAIL prio_cycle: got %0d want 4", cycle_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (99) tick();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL to_early: got %0d want 0", halted); end
        tick();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL to_halted: got %0d want 1", halted); end
        vectors++; if (halt_cause !== 2'd3) begin miscompares++; $display("FAIL to_cause: got %0d want 3", halt_cause); end
        vectors++; if (cycle_cnt !== 64'd100) begin miscompares++; $display("FAIL to_cycle: got %0d want 100", cycle_cnt); end
        repeat (20) tick();
        vectors++; if (cycle_cnt !== 64'd100) begin miscompares++; $display("FAIL to_cycle_frozen: got %0d want 100", cycle_cnt); end
    endtask

    task automatic test_retire();
        apply_reset();
        retire_valid = 1'b1;
        repeat (20) tick();
        ecall_pulse = 1'b1; tick(); ecall_pulse = 1'b0;
        vectors++; if (retire_cnt !== 64'd21) begin miscompares++; $display("FAIL ret_halt: got %0d want 21", retire_cnt); end
        vectors++; if (halt_cause !== 2'd1) begin miscompares++; $display("FAIL ret_cause: got %0d want 1", halt_cause); end
        repeat (4) tick();
        vectors++; if (retire_cnt !== 64'd25) begin miscompares++; $display("FAIL ret_drain: got %0d want 25", retire_cnt); end
        vectors++; if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL ret_valid: got %0d want 1", dump_valid); end
        repeat (5) tick();
        vectors++; if (retire_cnt !== 64'd25) begin miscompares++; $display("FAIL ret_frozen: got %0d want 25", retire_cnt); end
        vectors++; if (dump_idx !== 5'd0 || dump_valid !== 1'b1) begin
            miscompares++; $display("FAIL ret_stall_hold: got idx %0d valid %0d want 0/1", dump_idx, dump_valid);
        end
        retire_valid = 1'b0;
    endtask

    task automatic test_stall_dump();
        logic [31:0] exp;
        apply_reset();
        tick(); tick();
        ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 32; i++) begin
            exp = (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
            dump_ready = 1'b0; tick();
            vectors++; if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL st_valid%0d: got %0d want 1", i, dump_valid); end
            vectors++; if (dump_idx !== 5'(i)) begin miscompares++; $display("FAIL st_idx%0d: got %0d want %0d", i, dump_idx, i); end
            vectors++; if (dump_data !== exp) begin miscompares++; $display("FAIL st_data%0d: got %h want %h", i, dump_data, exp); end
            dump_ready = 1'b1; tick();
        end
        dump_ready = 1'b0;
        vectors++; if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            miscompares++; $display("FAIL st_done: got done %0d valid %0d want 1/0", dump_done, dump_valid);
        end
        repeat (5) tick();
        vectors++; if (dump_done !== 1'b1 || core_freeze !== 1'b1 || dump_idx !== 5'd31) begin
            miscompares++; $display("FAIL st_done_hold: got done %0d freeze %0d idx %0d want 1/1/31", dump_done, core_freeze, dump_idx);
        end
    endtask

    task automatic test_reset_mid_dump();
        apply_reset();
        dump_ready = 1'b1;
        ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        repeat (4) tick();
        repeat (7) tick();
        vectors++; if (dump_idx !== 5'd7) begin miscompares++; $display("FAIL rm_idx7: got %0d want 7", dump_idx); end
        #2 rst = 1'b0;
        #1;
        vectors++; if ({halted, halt_cause, core_freeze, dump_valid, dump_done, rf_raddr, dump_idx} !== 16'd0) begin
            miscompares++; $display("FAIL rm_async_ctrl: got %b want 0", {halted, halt_cause, core_freeze, dump_valid, dump_done, rf_raddr, dump_idx});
        end
        vectors++; if (cycle_cnt !== 64'd0 || retire_cnt !== 64'd0 || dump_data !== 32'd0) begin
            miscompares++; $display("FAIL rm_async_data: got cyc %0d ret %0d data %h want 0", cycle_cnt, retire_cnt, dump_data);
        end
        tick();
        rst = 1'b1;
        repeat (5) tick();
        vectors++; if (cycle_cnt !== 64'd5) begin miscompares++; $display("FAIL rm_restart_cycle: got %0d want 5", cycle_cnt); end
        ebreak_pulse = 1'b1; tick(); ebreak_pulse = 1'b0;
        vectors++; if (cycle_cnt !== 64'd6 || halt_cause !== 2'd2) begin
            miscompares++; $display("FAIL rm_rehalt: got cyc %0d cause %0d want 6/2", cycle_cnt, halt_cause);
        end
        repeat (4) tick();
        for (int i = 0; i < 32; i++) begin
            vectors++; if (dump_idx !== 5'(i) || dump_valid !== 1'b1) begin
                miscompares++; $display("FAIL rm_beat%0d: got idx %0d valid %0d want %0d/1", i, dump_idx, dump_valid, i);
            end
            tick();
        end
        vectors++; if (dump_done !== 1'b1) begin miscompares++; $display("FAIL rm_done: got %0d want 1", dump_done); end
    endtask

    task automatic test_no_timeout();
        logic [63:0] frozen;
        int guard = 0;
        while (b_edges < 64'd1000 && guard < 2000) begin
            tick();
            guard++;
        end
        vectors++; if (b_edges < 64'd1000) begin miscompares++; $display("FAIL nt_budget: got %0d edges want >=1000", b_edges); end
        vectors++; if (b_halted !== 1'b0) begin miscompares++; $display("FAIL nt_halted: got %0d want 0", b_halted); end
        vectors++; if (b_cycle !== b_edges) begin miscompares++; $display("FAIL nt_cycle: got %0d want %0d", b_cycle, b_edges); end
        b_ebreak = 1'b1; tick(); b_ebreak = 1'b0;
        frozen = b_edges;
        vectors++; if (b_halted !== 1'b1 || b_cause !== 2'd2) begin
            miscompares++; $display("FAIL nt_halt: got halted %0d cause %0d want 1/2", b_halted, b_cause);
        end
        vectors++; if (b_valid !== 1'b1 || b_idx !== 5'd0) begin
            miscompares++; $display("FAIL nt_drain0: got valid %0d idx %0d want 1/0", b_valid, b_idx);
        end
        tick();
        vectors++; if (b_cycle !== frozen) begin miscompares++; $display("FAIL nt_frozen: got %0d want %0d", b_cycle, frozen); end
    endtask

    initial begin
        rst = 1'b0;
        ecall_pulse = 1'b0; ebreak_pulse = 1'b0; retire_valid = 1'b0; dump_ready = 1'b0;
        b_rst = 1'b0; b_ecall = 1'b0; b_ebreak = 1'b0; b_retire = 1'b0; b_ready = 1'b1;
        tick(); tick();
        b_rst = 1'b1;
        test_reset();
        test_ebreak_dump();
        test_priority();
        test_timeout();
        test_retire();
        test_stall_dump();
        test_reset_mid_dump();
        test_no_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
